// File: rtl/mcp3202_pkg.sv
// Shared types and helpers for the MCP3202-compatible SPI responder.
// Command-field positions are indices of the CFG bit counter after the start bit.
package mcp3202_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CFG,
    ST_NULL,
    ST_MSB_OUT,
    ST_LSB_OUT,
    ST_TAIL
  } state_t;

  localparam logic [1:0] CMD_SGL_DIFF = 2'd0;
  localparam logic [1:0] CMD_ODD_SIGN = 2'd1;
  localparam logic [1:0] CMD_MSBF     = 2'd2;

  localparam int CODE_MAX_W = 16;

  // Saturating a - b: clamps at zero instead of wrapping.
  function automatic logic [CODE_MAX_W-1:0] diff_sat(input logic [CODE_MAX_W-1:0] a,
                                                     input logic [CODE_MAX_W-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/mcp3202_spi_responder_sync_edge_det.sv
// Multi-flop synchronizer with a previous-value flop for edge detection.
// level/rise/fall are all referenced to the synchronized copy of din.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, din});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcp3202_spi_responder.sv
// MCP3202-style ADC emulator: oversampled SPI mode 0,0 responder that decodes the
// 4-bit command and returns a 12-bit code derived from two parallel channel inputs.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | chipselect high, or not yet seen high since reset
// WAIT_START | selected, skipping leading zeros until the start bit
// CFG        | capturing sgl_diff, odd_sign, msbf on three rises
// NULL       | next fall drives the null bit and enables the output
// MSB_OUT    | falls shift out code[DATA_W-1] down to code[0]
// LSB_OUT    | falls shift out code[1] up to code[DATA_W-1] (msbf=0 only)
// TAIL       | frame done, drive zeros until deselected
module mcp3202_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              chipselect,
  input  logic              mosi_din,
  output logic              dout_miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              conv_valid,
  output logic [DATA_W-1:0] conv_code
);

  import mcp3202_pkg::*;

  localparam int IW = $clog2(DATA_W);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_s, cs_rise_unused, cs_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_clk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(chipselect),
    .level(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi_din),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              sgl_q, sgl_d, odd_q, odd_d, msbf_q, msbf_d;
  logic              dout_q, dout_d, oe_q, oe_d, cv_q, cv_d;
  logic [DATA_W-1:0] code_q, code_d, calc_code;

  // The chipselect synchronizer resets to "high"; only trust it once it has been
  // refilled from the pin, so a reset mid-frame needs a real deselect to re-arm.
  logic [SYNC_STAGES-1:0] rdy_q;
  logic                   armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rdy_q   <= SYNC_STAGES'({rdy_q, 1'b1});
      armed_q <= armed_q | (rdy_q[SYNC_STAGES-1] & cs_s);
    end
  end

  always_comb begin
    calc_code = '0;
    if (sgl_q) calc_code = odd_q ? ch1_data : ch0_data;
    else if (odd_q) calc_code = DATA_W'(diff_sat(CODE_MAX_W'(ch1_data), CODE_MAX_W'(ch0_data)));
    else calc_code = DATA_W'(diff_sat(CODE_MAX_W'(ch0_data), CODE_MAX_W'(ch1_data)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sgl_q   <= 1'b0;
      odd_q   <= 1'b0;
      msbf_q  <= 1'b0;
      dout_q  <= 1'b0;
      oe_q    <= 1'b0;
      cv_q    <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sgl_q   <= sgl_d;
      odd_q   <= odd_d;
      msbf_q  <= msbf_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      cv_q    <= cv_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sgl_d   = sgl_q;
    odd_d   = odd_q;
    msbf_d  = msbf_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    cv_d    = 1'b0;
    code_d  = code_q;

    // Deselect overrides any SPI clock edge seen in the same cycle.
    if (cs_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      dout_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q) state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (sclk_rise && mosi_s) begin
            state_d = ST_CFG;
            cnt_d   = '0;
          end
        end
        ST_CFG: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              CMD_SGL_DIFF: sgl_d = mosi_s;
              CMD_ODD_SIGN: odd_d = mosi_s;
              default: begin
                msbf_d  = mosi_s;
                code_d  = calc_code;
                cv_d    = 1'b1;
                state_d = ST_NULL;
              end
            endcase
          end
        end
        ST_NULL: begin
          if (sclk_fall) begin
            oe_d    = 1'b1;
            dout_d  = 1'b0;
            idx_d   = IW'(DATA_W - 1);
            state_d = ST_MSB_OUT;
          end
        end
        ST_MSB_OUT: begin
          if (sclk_fall) begin
            dout_d = code_q[idx_q];
            if (idx_q == '0) begin
              if (msbf_q) begin
                state_d = ST_TAIL;
              end else begin
                state_d = ST_LSB_OUT;
                idx_d   = IW'(1);
              end
            end else begin
              idx_d = idx_q - IW'(1);
            end
          end
        end
        ST_LSB_OUT: begin
          if (sclk_fall) begin
            dout_d = code_q[idx_q];
            if (idx_q == IW'(DATA_W - 1)) state_d = ST_TAIL;
            else idx_d = idx_q + IW'(1);
          end
        end
        ST_TAIL: begin
          if (sclk_fall) dout_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign dout_miso  = dout_q;
  assign miso_oe    = oe_q;
  assign conv_valid = cv_q;
  assign conv_code  = code_q;

endmodule
